prefetch_queue: RTL and testbench

//  Owns the fetch PC and buffers completed instructions between the byte-serial fetch stage and decode.

---
 rtl/prefetch_queue_pkg.sv | 19 +
 rtl/prefetch_queue_if.sv | 32 +++
 rtl/prefetch_queue_sync_fifo.sv | 58 +++++
 rtl/prefetch_queue.sv | 67 ++++++
 tb/tb_prefetch_queue.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared widths, the queue entry layout and the PC increment used by the prefetch queue.
package prefetch_queue_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int INST_WIDTH  = 32;
    localparam int INST_BYTES  = INST_WIDTH / 8;
    localparam int ENTRY_WIDTH = WORD_WIDTH + INST_WIDTH;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    // Sequential fetch address; wraps modulo 2^WORD_WIDTH.
    function automatic logic [WORD_WIDTH-1:0] next_pc(input logic [WORD_WIDTH-1:0] pc);
        return pc + WORD_WIDTH'(INST_BYTES);
    endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// Fetch-side, redirect and decode-side signals of the prefetch queue.
// The master modport is the queue itself; slave is its environment.
interface prefetch_queue_if #(
    parameter int DEPTH = 4
) ();
    import prefetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_WIDTH-1:0] fetch_pc;
    logic                  fetch_rst;
    logic [INST_WIDTH-1:0] fetch_inst;
    logic                  fetch_ready;
    logic                  redirect;
    logic [WORD_WIDTH-1:0] redirect_pc;
    logic                  valid;
    logic [INST_WIDTH-1:0] inst;
    logic [WORD_WIDTH-1:0] pc;
    logic                  dec_ready;
    logic [CW-1:0]         count;

    modport master (
        output fetch_pc, fetch_rst, valid, inst, pc, count,
        input  fetch_inst, fetch_ready, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  fetch_pc, fetch_rst, valid, inst, pc, count,
        output fetch_inst, fetch_ready, redirect, redirect_pc, dec_ready
    );

endinterface

// File: rtl/prefetch_queue_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; the head entry is read
// combinationally so it is visible in the same cycle the count turns non-zero.
module prefetch_queue_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/prefetch_queue.sv
// Owns the fetch PC, buffers {pc, inst} from the byte-serial fetch stage for decode,
// and flushes/restarts fetch on a branch redirect.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int                    DEPTH    = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    prefetch_queue_if.master   io_q
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_WIDTH-1:0] r_fetch_pc;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_count;
    entry_t                w_wr_entry;
    entry_t                w_head;

    // Redirect wins over both ends; fetch is held in reset while full, so a
    // ready pulse can never arrive with the queue full.
    assign w_push = io_q.fetch_ready & ~io_q.redirect & ~w_full;
    assign w_pop  = ~w_empty & io_q.dec_ready & ~io_q.redirect;

    assign w_wr_entry.pc   = r_fetch_pc;
    assign w_wr_entry.inst = io_q.fetch_inst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (io_q.redirect) begin
            r_fetch_pc <= io_q.redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= next_pc(r_fetch_pc);
        end
    end

    prefetch_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (io_q.redirect),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A partial fetch is discarded whenever this is high; it restarts at fetch_pc.
    assign io_q.fetch_rst = i_rst | io_q.redirect | w_full;
    assign io_q.fetch_pc  = r_fetch_pc;
    assign io_q.valid     = ~w_empty;
    assign io_q.pc        = w_head.pc;
    assign io_q.inst      = w_head.inst;
    assign io_q.count     = w_count;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed and random checks of prefetch_queue against a byte-serial fetch model and a queue model.
module tb_prefetch_queue;
    import prefetch_queue_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hC0DE_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   f_cnt = 0;
    bit   m_on = 1'b0;
    logic [63:0] mq[$];
    logic [31:0] mpc;
    int   n;

    always #5 clk = ~clk;

    prefetch_queue_if #(.DEPTH(DEPTH)) dif ();

    prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h100)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_q  (dif)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: fetch model drives ready/inst, model is compared, then both advance.
    task automatic tick();
        logic f_rst;
        bit   m_push;
        bit   m_pop;
        dif.fetch_ready = (f_cnt == INST_BYTES);
        dif.fetch_inst  = dif.fetch_pc ^ KEY;
        #1;
        f_rst  = dif.fetch_rst;
        m_push = dif.fetch_ready && !dif.redirect && (mq.size() != DEPTH);
        m_pop  = (mq.size() != 0) && dif.dec_ready && !dif.redirect;
        if (m_on && !rst) begin
            check_val("m_count", 64'(dif.count), 64'(mq.size()));
            check_val("m_fetch_pc", 64'(dif.fetch_pc), 64'(mpc));
            check_val("m_fetch_rst", 64'(f_rst),
                      64'(dif.redirect || (mq.size() == DEPTH)));
            if (mq.size() != 0) check_val("m_head", {dif.pc, dif.inst}, mq[0]);
            if (dif.fetch_ready && !dif.redirect)
                check_val("no_push_full", 64'(int'(dif.count) == DEPTH), 64'd0);
        end
        @(posedge clk);
        if (f_rst || f_cnt == INST_BYTES) f_cnt = 0;
        else f_cnt++;
        if (rst) begin
            mq.delete();
            mpc = 32'h100;
        end else if (dif.redirect) begin
            mq.delete();
            mpc = dif.redirect_pc;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({mpc, dif.fetch_inst});
                mpc = mpc + 32'(INST_BYTES);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_fetch_rst", 64'(dif.fetch_rst), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        m_on = 1'b1;
        #1;
        check_val("rst_valid", 64'(dif.valid), 64'd0);
        check_val("rst_count", 64'(dif.count), 64'd0);
        check_val("rst_fetch_pc", 64'(dif.fetch_pc), 64'h100);
        check_val("rst_fetch_rst_low", 64'(dif.fetch_rst), 64'd0);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!dif.valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check_val("wait_valid", 64'(dif.valid), 64'd1);
    endtask

    task automatic wait_count(input int target);
        int c = 0;
        while (int'(dif.count) != target && c < 60) begin
            tick();
            c++;
        end
        check_val("wait_count", 64'(dif.count), 64'(target));
    endtask

    task automatic wait_fetch_ready();
        int c = 0;
        while (f_cnt != INST_BYTES && c < 20) begin
            tick();
            c++;
        end
        check_val("fetch_align", 64'(f_cnt), 64'(INST_BYTES));
    endtask

    task automatic show_head(input string what);
        $display("%s pc=0x%08h inst=0x%08h count=%0d", what, dif.pc, dif.inst, dif.count);
    endtask

    initial begin
        dif.dec_ready   = 1'b0;
        dif.redirect    = 1'b0;
        dif.redirect_pc = '0;
        dif.fetch_ready = 1'b0;
        dif.fetch_inst  = '0;
        mpc = 32'h100;

        // Reset and in-order stream with decode always ready
        do_reset();
        dif.dec_ready = 1'b1;
        wait_valid(n);
        check_val("first_latency", 64'(n), 64'd5);
        check_val("s0_pc", 64'(dif.pc), 64'h100);
        check_val("s0_inst", 64'(dif.inst), 64'hC0DE0100);
        check_val("s0_fetch_pc", 64'(dif.fetch_pc), 64'h104);
        show_head("pop");
        tick();
        wait_valid(n);
        check_val("s1_pc", 64'(dif.pc), 64'h104);
        check_val("s1_inst", 64'(dif.inst), 64'hC0DE0104);
        show_head("pop");
        tick();
        wait_valid(n);
        check_val("s2_pc", 64'(dif.pc), 64'h108);
        check_val("s2_inst", 64'(dif.inst), 64'hC0DE0108);
        show_head("pop");
        tick();

        // Fill to DEPTH: fetch held in reset, PC frozen
        do_reset();
        dif.dec_ready = 1'b0;
        wait_count(DEPTH);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("full_fetch_rst", 64'(dif.fetch_rst), 64'd1);
            check_val("full_fetch_pc", 64'(dif.fetch_pc), 64'h110);
        end
        check_val("full_head", 64'(dif.pc), 64'h100);
        dif.dec_ready = 1'b1;
        #1;
        check_val("pop_cycle_fetch_rst", 64'(dif.fetch_rst), 64'd1);
        tick();
        dif.dec_ready = 1'b0;
        #1;
        check_val("after_pop_count", 64'(dif.count), 64'd3);
        check_val("after_pop_fetch_rst", 64'(dif.fetch_rst), 64'd0);
        wait_count(DEPTH);
        check_val("refill_fetch_pc", 64'(dif.fetch_pc), 64'h114);
        dif.dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("drain_pc", 64'(dif.pc), 64'(32'h104 + 32'(4 * i)));
            show_head("pop");
            tick();
        end

        // Redirect with 3 queued and a coincident fetch ready
        do_reset();
        dif.dec_ready = 1'b0;
        wait_count(3);
        wait_fetch_ready();
        check_val("pre_redirect_pc", 64'(dif.fetch_pc), 64'h10C);
        dif.redirect    = 1'b1;
        dif.redirect_pc = 32'h200;
        #1;
        check_val("redirect_fetch_rst", 64'(dif.fetch_rst), 64'd1);
        tick();
        dif.redirect = 1'b0;
        #1;
        check_val("redirect_count", 64'(dif.count), 64'd0);
        check_val("redirect_valid", 64'(dif.valid), 64'd0);
        check_val("redirect_fetch_pc", 64'(dif.fetch_pc), 64'h200);
        wait_valid(n);
        check_val("redirect_latency", 64'(n + 1), 64'd6);
        check_val("redirect_pc_out", 64'(dif.pc), 64'h200);
        check_val("redirect_inst", 64'(dif.inst), 64'hC0DE0200);
        show_head("head");

        // Simultaneous push and pop at count 2 across pointer wrap
        dif.redirect    = 1'b1;
        dif.redirect_pc = 32'h300;
        tick();
        dif.redirect = 1'b0;
        wait_count(2);
        for (int i = 0; i < 12; i++) begin
            wait_fetch_ready();
            check_val("pp_pc", 64'(dif.pc), 64'(32'h300 + 32'(4 * i)));
            check_val("pp_inst", 64'(dif.inst), 64'((32'h300 + 32'(4 * i)) ^ KEY));
            show_head("pop");
            dif.dec_ready = 1'b1;
            tick();
            dif.dec_ready = 1'b0;
            check_val("pp_count", 64'(dif.count), 64'd2);
        end

        // Fetch PC wrap at the top of the address space
        dif.dec_ready   = 1'b1;
        dif.redirect    = 1'b1;
        dif.redirect_pc = 32'hFFFF_FFFC;
        tick();
        dif.redirect = 1'b0;
        wait_valid(n);
        check_val("wrap_pc", 64'(dif.pc), 64'hFFFFFFFC);
        check_val("wrap_inst", 64'(dif.inst), 64'h3F21FFFC);
        check_val("wrap_fetch_pc", 64'(dif.fetch_pc), 64'h0);
        tick();
        wait_valid(n);
        check_val("wrap_next_pc", 64'(dif.pc), 64'h0);
        check_val("wrap_next_inst", 64'(dif.inst), 64'hC0DE0000);

        // Reset mid-fetch with a non-empty queue
        dif.dec_ready = 1'b0;
        tick();
        tick();
        check_val("mid_count", 64'(dif.count), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("mid_rst_count", 64'(dif.count), 64'd0);
        check_val("mid_rst_valid", 64'(dif.valid), 64'd0);
        check_val("mid_rst_fetch_pc", 64'(dif.fetch_pc), 64'h100);
        check_val("mid_rst_fetch_rst", 64'(dif.fetch_rst), 64'd0);

        // Random decode back-pressure and redirects against the queue model
        for (int i = 0; i < 1500; i++) begin
            dif.dec_ready   = 1'($urandom_range(0, 1));
            dif.redirect    = ($urandom_range(0, 24) == 0);
            dif.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom();
            tick();
        end
        dif.redirect = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
